// File: rtl/not10_share_ctrl_pkg.sv
// Shared definitions for the not10bit sharing controller.
//   CA_WIDTH : operand/result width of the shared not10bit inverter.
//   state_e  : controller FSM encoding (2'd3 is unused and recovers to IDLE).
package not10_share_ctrl_pkg;

    localparam int CA_WIDTH = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/not10_share_ctrl_not10bit.sv
// not10bit: pure bitwise inverter shared by all requesters of the controller.
// Ports:
//   data_in : operand (WIDTH bits)
//   res     : ~data_in (WIDTH bits), combinational
module not10bit
    import not10_share_ctrl_pkg::*;
#(
    parameter int WIDTH = CA_WIDTH
) (
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] res
);

    assign res = ~data_in;

endmodule

// File: rtl/not10_share_ctrl.sv
// not10_share_ctrl: round-robin arbiter that time-shares one not10bit inverter
// between NREQ requesters. Each operation runs IDLE -> GRANT -> DONE, so one
// result is produced at most every three cycles.
// Ports:
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   req       : per-requester request level (bit i = requester i)
//   data_in   : operands, requester i on [i*WIDTH +: WIDTH]
//   gnt       : registered one-hot grant pulse (1 cycle)
//   res       : registered inverted operand, held until the next result
//   res_valid : result strobe (1 cycle)
//   res_id    : requester index that owns res
//   busy      : high whenever the FSM is not in IDLE
module not10_share_ctrl
    import not10_share_ctrl_pkg::*;
#(
    parameter int WIDTH = CA_WIDTH,
    parameter int NREQ  = 2,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] data_in,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      res,
    output logic                  res_valid,
    output logic [IDW-1:0]        res_id,
    output logic                  busy
);

    state_e             state_q;
    logic [IDW-1:0]     rr_ptr_q;
    logic [IDW-1:0]     id_q;
    logic [WIDTH-1:0]   op_q;
    logic [NREQ-1:0]    gnt_q;
    logic [WIDTH-1:0]   res_q;
    logic               res_valid_q;
    logic [IDW-1:0]     res_id_q;

    logic               found_d;
    logic [IDW-1:0]     win_d;
    logic [WIDTH-1:0]   op_d;
    logic [NREQ-1:0]    gnt_d;
    logic [IDW-1:0]     rr_ptr_d;
    logic [WIDTH-1:0]   inv_res;

    // Round-robin search: first set request at or above ptr, wrapping modulo
    // NREQ. The request vector is doubled and rotated so bit 0 of rot is
    // always the candidate under test; indices >= NREQ can never be chosen.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] r,
                                             input logic [IDW-1:0]  ptr);
        logic [2*NREQ-1:0] rot;
        logic              found;
        logic [IDW-1:0]    win;
        rot   = {r, r} >> ptr;
        found = 1'b0;
        win   = '0;
        for (int off = 0; off < NREQ; off++) begin
            if (!found && rot[0]) begin
                found = 1'b1;
                win   = IDW'((int'(ptr) + off) % NREQ);
            end
            rot = rot >> 1;
        end
        return {found, win};
    endfunction

    always_comb begin
        {found_d, win_d} = rr_pick(req, rr_ptr_q);
        op_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_d == IDW'(i)) begin
                op_d = data_in[i*WIDTH +: WIDTH];
            end
        end
        gnt_d    = NREQ'(1) << win_d;
        rr_ptr_d = IDW'((int'(win_d) + 1) % NREQ);
    end

    not10bit #(
        .WIDTH (WIDTH)
    ) u_inv (
        .data_in (op_q),
        .res     (inv_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            op_q        <= '0;
            gnt_q       <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
        end else begin
            // Strobes are single-cycle; only the active state re-raises them.
            gnt_q       <= '0;
            res_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (found_d) begin
                        gnt_q    <= gnt_d;
                        op_q     <= op_d;
                        id_q     <= win_d;
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    res_q       <= inv_res;
                    res_id_q    <= id_q;
                    res_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign res       = res_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
